lstm_cell_update: RTL

- Downstream consumer of the gate pre-activation vector A[0:399], where A = Wx*x + Wh*h_prev + b.
- Splits A into four 100-wide gates: i = A[0:99], f = A[100:199], g = A[200:299], o = A[300:399].
- Applies hard activations and updates the persistent cell state: c = f*c_prev + i*g, then h = o*tanh(c).
- Processes one hidden unit per cycle through a 3-stage pipeline. The h output feeds h_prev of the next timestep.

---
 rtl/lstm_fx_pkg.sv | 64 ++++++
 rtl/lstm_cell_update_pipe.sv | 77 +++++++
 rtl/lstm_cell_update.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lstm_fx_pkg.sv
// Q16.16 fixed-point helpers shared by the LSTM cell-update datapath.
// Contents: data width/fraction constants, fx_t word type, controller state
// encoding, and the saturating activation/arithmetic functions.
package lstm_fx_pkg;

  localparam int W    = 32;
  localparam int FRAC = 16;

  typedef logic signed [W-1:0] fx_t;

  localparam fx_t ONE     = fx_t'(65536);
  localparam fx_t HALF    = fx_t'(32768);
  localparam fx_t NEG_ONE = fx_t'(-65536);
  localparam fx_t FX_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam fx_t FX_MIN  = {1'b1, {(W-1){1'b0}}};

  // Saturation bounds expressed at product (2W) and sum (W+1) widths.
  localparam logic signed [2*W-1:0] P_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] P_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W:0]     S_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]     S_MIN = {2'b11, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // x/4 + 0.5 clamped to [0, 1]; x>>>2 cannot overflow after adding HALF.
  function automatic fx_t hard_sigmoid(input fx_t x);
    fx_t t;
    t = (x >>> 2) + HALF;
    if (t < 0) return '0;
    if (t > ONE) return ONE;
    return t;
  endfunction

  function automatic fx_t hard_tanh(input fx_t x);
    if (x > ONE) return ONE;
    if (x < NEG_ONE) return NEG_ONE;
    return x;
  endfunction

  // Full-width product, floor shift back to Q16.16, then clamp.
  function automatic fx_t fx_mul_sat(input fx_t a, input fx_t b);
    logic signed [2*W-1:0] p;
    logic signed [2*W-1:0] q;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    q = p >>> FRAC;
    if (q > P_MAX) return FX_MAX;
    if (q < P_MIN) return FX_MIN;
    return q[W-1:0];
  endfunction

  function automatic fx_t fx_add_sat(input fx_t a, input fx_t b);
    logic signed [W:0] s;
    s = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (s > S_MAX) return FX_MAX;
    if (s < S_MIN) return FX_MIN;
    return s[W-1:0];
  endfunction

endpackage

// File: rtl/lstm_cell_update_pipe.sv
// lstm_unit_pipe: three-stage per-hidden-unit datapath.
//   S1: hard activations of the raw gate words, capture c_prev.
//   S2: p1 = f*c_prev, p2 = i*g (saturating Q16.16 products).
//   S3: c_new = p1 + p2 (saturating), h_new = o * hard_tanh(c_new).
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valids only)
//   issue/issue_idx unit entering S1 and its index
//   i, f, g, o      raw gate pre-activations for that unit
//   c_prev          previous cell state for that unit
//   wr/wr_idx       S3 result valid and its index
//   c_new, h_new    S3 results
module lstm_unit_pipe
  import lstm_fx_pkg::*;
#(
  parameter int IW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [IW-1:0] issue_idx,
  input  fx_t           i,
  input  fx_t           f,
  input  fx_t           g,
  input  fx_t           o,
  input  fx_t           c_prev,
  output logic          wr,
  output logic [IW-1:0] wr_idx,
  output fx_t           c_new,
  output fx_t           h_new
);

  logic          s1_v;
  logic [IW-1:0] s1_idx;
  fx_t           s1_i, s1_f, s1_g, s1_o, s1_c;

  logic          s2_v;
  logic [IW-1:0] s2_idx;
  fx_t           s2_p1, s2_p2, s2_o;

  fx_t           c_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      wr   <= 1'b0;
    end else begin
      s1_v <= issue;
      s2_v <= s1_v;
      wr   <= s2_v;
    end
  end

  // Data registers need no reset: they are only consumed under their valid.
  always_ff @(posedge clk) begin
    s1_idx <= issue_idx;
    s1_i   <= hard_sigmoid(i);
    s1_f   <= hard_sigmoid(f);
    s1_g   <= hard_tanh(g);
    s1_o   <= hard_sigmoid(o);
    s1_c   <= c_prev;

    s2_idx <= s1_idx;
    s2_p1  <= fx_mul_sat(s1_f, s1_c);
    s2_p2  <= fx_mul_sat(s1_i, s1_g);
    s2_o   <= s1_o;

    wr_idx <= s2_idx;
    c_new  <= c_sum;
    h_new  <= fx_mul_sat(s2_o, hard_tanh(c_sum));
  end

  always_comb begin
    c_sum = fx_add_sat(s2_p1, s2_p2);
  end

endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell-state / hidden-state update over H units, one unit per cycle.
// Takes a snapshot of the 4*H gate pre-activations (i|f|g|o) on accept and
// streams each unit through lstm_unit_pipe, writing c_out/h_out in place.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   A            4*H signed gate pre-activations, sampled on accept
//   in_valid     A is valid;  in_ready: accepting (IDLE only)
//   clear_state  zero c_out/h_out while IDLE (wins over a same-edge accept)
//   h_out, c_out persistent state arrays, stable only when not busy
//   busy         RUN or DRAIN;  out_valid: one-cycle pulse after the last write
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for A; clear_state honoured here
// ST_RUN   | issuing unit idx = 0..H-1 into the pipe, one per cycle
// ST_DRAIN | pipe emptying; held until the final unit's write lands
// ST_DONE  | out_valid pulse, back to IDLE
module lstm_cell_update
  import lstm_fx_pkg::*;
#(
  parameter int H = 100
) (
  input  logic clk,
  input  logic rst,
  input  fx_t  A [0:4*H-1],
  input  logic in_valid,
  output logic in_ready,
  input  logic clear_state,
  output fx_t  h_out [0:H-1],
  output fx_t  c_out [0:H-1],
  output logic busy,
  output logic out_valid
);

  localparam int IW = $clog2(H);
  localparam int SW = $clog2(4*H);
  localparam logic [IW-1:0] LAST = IW'(H-1);

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [1:0]    drain_cnt;
  logic          accept;
  logic          issue;
  fx_t           snap [0:4*H-1];

  logic          wr;
  logic [IW-1:0] wr_idx;
  fx_t           c_new, h_new;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (idx == LAST) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Drain down-counter: the last issue needs three more edges to reach the
  // arrays (S2, S3, write), so DONE coincides with that final write.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      drain_cnt <= 2'd0;
    end else begin
      if (accept)
        idx <= '0;
      else if (issue && idx != LAST)
        idx <= idx + 1'b1;

      if (state == ST_RUN && idx == LAST)
        drain_cnt <= 2'd2;
      else if (state == ST_DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) snap <= A;
  end

  // c_prev is read from the live array: a unit's write lands four edges after
  // its own read and no other unit touches that entry, so no bypass is needed.
  lstm_unit_pipe #(.IW(IW)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .issue_idx (idx),
    .i         (snap[SW'(idx)]),
    .f         (snap[SW'(H) + SW'(idx)]),
    .g         (snap[SW'(2*H) + SW'(idx)]),
    .o         (snap[SW'(3*H) + SW'(idx)]),
    .c_prev    (c_out[idx]),
    .wr        (wr),
    .wr_idx    (wr_idx),
    .c_new     (c_new),
    .h_new     (h_new)
  );

  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE && clear_state)) begin
      for (int k = 0; k < H; k++) begin
        c_out[k] <= '0;
        h_out[k] <= '0;
      end
    end else if (wr) begin
      c_out[wr_idx] <= c_new;
      h_out[wr_idx] <= h_new;
    end
  end

endmodule
